gcd_controller: RTL
===================

Name: gcd_controller

Overview:
- Control FSM for the subtractive-GCD datapath. Drives `ldx`, `ldy`, `ldd`, `Sx`, `Sy` and `Ss`, and consumes the datapath status flags `xeqy` and `xgty`.
- Gives the system a start/busy/done handshake.
- Bounds the loop with an iteration limit. This turns the zero-operand non-termination case into an error report instead of a hang.
- Sits beside the datapath; together the two form the GCD unit.

Parameters:
ITER_W, 8, width of the subtraction counter
MAX_ITER, 255, maximum subtractions before abort; must be <= 2^ITER_W - 1

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
xeqy  input  1  datapath flag: x == y
xgty  input  1  datapath flag: x > y
ldx  output  1  load x register
ldy  output  1  load y register
ldd  output  1  load result register (d <= x)
Sx  output  1  x mux select: 0 = x_i, 1 = subtractor result
Sy  output  1  y mux select: 0 = y_i, 1 = subtractor result
Ss  output  1  subtractor order: 0 = x - y, 1 = y - x
busy  output  1  high in LOAD and RUN
done  output  1  one-cycle completion pulse
err  output  1  valid with done; 1 = iteration limit hit, d not updated

Behaviour:
- Clock and reset:
  - Clock is `clk`. Reset `rst` is synchronous and active-high.
  - On reset the state goes to IDLE and the counter clears to 0.
  - All outputs are 0 after reset: ldx, ldy, ldd, Sx, Sy, Ss, busy, done, err.
- States: IDLE, LOAD, RUN, DONE. State is registered; datapath controls are combinational from state and flags.
- IDLE:
  - All controls are 0.
  - start=1 moves to LOAD. Otherwise the FSM stays in IDLE.
- LOAD:
  - Outputs: ldx=1, ldy=1, Sx=0, Sy=0, busy=1.
  - Clears the counter and moves to RUN unconditionally.
- RUN (busy=1). Priority order per cycle:
  1. xeqy=1: ldd=1, moves to DONE with err_next=0.
  2. Else if count == MAX_ITER: no loads, moves to DONE with err_next=1.
  3. Else if xgty=1: ldx=1, Sx=1, Ss=0 (x <= x - y); count++; stays in RUN.
  4. Else: ldy=1, Sy=1, Ss=1 (y <= y - x); count++; stays in RUN.
- DONE:
  - done=1 for exactly one cycle; err holds the registered err_next.
  - Moves to IDLE unconditionally.
  - err stays 0 outside DONE.
- Select lines when their load is low: Sx, Sy and Ss are driven 0 (don't-care to the datapath, but fixed for lint and equivalence).
- Latency:
  - start high in cycle 0, LOAD in cycle 1, RUN in cycles 2 .. 2+N, where N is the number of subtractions.
  - done in cycle 3+N.
  - The result is on d_o from cycle 3+N on and holds until the next successful operation.
- Boundary conditions:
  - start while busy or in DONE is ignored. There is no queuing; start must be reasserted from IDLE.
  - A zero operand never converges. The FSM aborts after MAX_ITER subtractions and asserts done with err=1 in cycle 3+MAX_ITER.
  - The counter saturates logically: comparison happens before increment, so it never wraps.
  - rst mid-operation returns the FSM to IDLE on the next edge with all outputs 0. Datapath registers have no reset, so d keeps its stale value.
  - rst has priority over start in the same cycle.

Optional Feature:
- Macro GCD_CTRL_ITER_OUT_EN.
- When defined:
  - Adds port `iter_o`, output, ITER_W bits.
  - `iter_o` is registered on the DONE transition with the final count, and holds until the next DONE.
  - Reset value 0.
- When undefined: the port and its register are absent; behaviour is otherwise identical.

Test Plan:
- x_i=12, y_i=8, start pulse at cycle 0:
  - RUN does 2 subtractions (x=4, then y=4).
  - done=1, err=0 at cycle 5; d_o=4; iter_o=2 if enabled.
- x_i=7, y_i=7:
  - N=0, ldd in cycle 2.
  - done at cycle 3, err=0, d_o=7.
- x_i=255, y_i=1:
  - 254 subtractions with ldx/Sx=1, Ss=0.
  - done at cycle 257, d_o=1, err=0.
- x_i=0, y_i=5:
  - 255 subtractions with ldy/Sy=1, Ss=1, y stays 5.
  - done at cycle 258 with err=1; ldd never asserted.
- start re-pulsed during RUN of the 12/8 case: no restart, single done at cycle 5. Then rst asserted at cycle 3 of a new run: next cycle IDLE, all outputs 0, no done.
- Reset check: rst held 2 cycles from power-up with start=1 → all outputs 0, FSM in IDLE. Releasing rst with start=1 → LOAD next cycle.

Source files
------------

// File: rtl/gcd_controller.sv
// gcd_controller: start/busy/done control FSM for a subtractive GCD datapath with an iteration-limit abort.
// Define GCD_CTRL_ITER_OUT_EN to add iter_o, the registered subtraction count of the last completed operation.
module gcd_controller #(
    parameter int ITER_W   = 8,
    parameter int MAX_ITER = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              xeqy,
    input  logic              xgty,
    output logic              ldx,
    output logic              ldy,
    output logic              ldd,
    output logic              Sx,
    output logic              Sy,
    output logic              Ss,
    output logic              busy,
    output logic              done,
`ifdef GCD_CTRL_ITER_OUT_EN
    output logic [ITER_W-1:0] iter_o,
`endif
    output logic              err
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
    state_t state_q, state_d;
    logic [ITER_W-1:0] cnt_q, cnt_d;
    logic err_q, err_d;
    logic at_max, run_sub;
    // Limit is checked before the increment, so the counter never wraps.
    assign at_max = cnt_q == ITER_W'(MAX_ITER);
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: state_d = start ? LOAD : IDLE;
            LOAD: begin
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                if (xeqy || at_max) begin
                    state_d = DONE;
                    err_d   = !xeqy;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        run_sub = state_q == RUN && !xeqy && !at_max;
        busy    = state_q == LOAD || state_q == RUN;
        done    = state_q == DONE;
        err     = done && err_q;
        ldd     = state_q == RUN && xeqy;
        Sx      = run_sub && xgty;
        Sy      = run_sub && !xgty;
        Ss      = Sy;
        ldx     = state_q == LOAD || Sx;
        ldy     = state_q == LOAD || Sy;
    end
`ifdef GCD_CTRL_ITER_OUT_EN
    logic [ITER_W-1:0] iter_q;
    always_ff @(posedge clk) begin
        if (rst)
            iter_q <= '0;
        else if (state_q == RUN && state_d == DONE)
            iter_q <= cnt_q;
    end
    assign iter_o = iter_q;
`endif
endmodule
